clk_ctrl: RTL

Run-control and clock-enable scheduler for the SoC core clock domain. Replaces free-running division with a programmable divider whose output is a single-cycle enable, `clk_en`, used by all core flops on `CLK`. Sequences the core reset release and lets the debug/host side halt, single-step, resume and soft-reset the core through a small register port.

---
 rtl/clk_ctrl_pkg.sv | 23 ++
 rtl/clk_ctrl_tick_gen.sv | 44 ++++
 rtl/clk_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg
//   Shared definitions for the core run-control / clock-enable scheduler:
//   the controller state encoding (also visible through STATUS[1:0]),
//   the register map addresses and the CTRL register bit positions.
package clk_ctrl_pkg;

  // Encoding is architecturally visible in STATUS[1:0], so values are fixed.
  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } ctrl_state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DIV    = 2'd1;
  localparam logic [1:0] ADDR_TICKS  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_RUN  = 0;
  localparam int CTRL_SRST = 1;

endpackage

// File: rtl/clk_ctrl_tick_gen.sv
// tick_gen
//   Programmable down-counter producing a single-cycle tick every div+1
//   enabled cycles.
// Ports:
//   CLK, RESET : system clock, synchronous active-high reset
//   enable     : counter advances (and may tick) only while high
//   reload     : load cnt from div this cycle, overriding counting
//   div        : period minus one
//   tick       : high in any enabled cycle where cnt is zero
module tick_gen
  import clk_ctrl_pkg::*;
#(
  parameter int DIV_W       = 24,
  parameter int DIV_DEFAULT = 256
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             enable,
  input  logic             reload,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = enable && (cnt == '0);

  // The period in flight always completes: div is only sampled when the
  // counter wraps or when an explicit reload is requested.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt <= DIV_W'(DIV_DEFAULT - 1);
    end else if (reload) begin
      cnt <= div;
    end else if (enable) begin
      if (cnt == '0) begin
        cnt <= div;
      end else begin
        cnt <= cnt - DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_ctrl.sv
// clk_ctrl
//   Run-control and clock-enable scheduler for the core clock domain.
//   Generates the core clock-enable, sequences core reset release and
//   exposes halt / single-step / resume / soft-reset through a small
//   register port.
// Ports:
//   CLK, RESET        : system clock, synchronous active-high reset
//   cfg_we, cfg_addr  : register write strobe and select (CTRL/DIV/TICKS/STATUS)
//   cfg_wdata         : register write data
//   cfg_rdata         : registered read data, one cycle after cfg_addr
//   step_req          : single-step request level (edge-armed)
//   step_ack          : pulses together with the clk_en of a step
//   clk_en            : single-cycle core clock enable
//   resetn            : core reset, active low
//   running           : high while in RUN
module clk_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DIV_W       = 24,
  parameter int DIV_DEFAULT = 256,
  parameter int RST_HOLD    = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  input  logic        step_req,
  output logic        step_ack,
  output logic        clk_en,
  output logic        resetn,
  output logic        running
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  ctrl_state_t       state;
  ctrl_state_t       state_next;
  logic [DIV_W-1:0]  div_q;
  logic              run_q;
  logic              run_next;
  logic [31:0]       ticks;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_last;
  logic              armed;
  logic              supp;
  logic              tick;
  logic              enable;
  logic              reload;
  logic              ctrl_wr;
  logic              div_wr;
  logic              srst;
  logic [31:0]       rd_next;
  logic              unused_wdata;

  assign unused_wdata = &{1'b0, cfg_wdata};

  assign ctrl_wr   = cfg_we && (cfg_addr == ADDR_CTRL);
  assign div_wr    = cfg_we && (cfg_addr == ADDR_DIV);
  assign srst      = ctrl_wr && cfg_wdata[CTRL_SRST];
  assign run_next  = ctrl_wr ? cfg_wdata[CTRL_RUN] : run_q;
  assign hold_last = (hold_cnt == HOLD_W'(RST_HOLD - 1));

  // supp masks exactly one cycle after a soft reset with div==0, where the
  // freshly reloaded counter would otherwise tick immediately.
  assign enable   = !RESET && !supp && (state != ST_HALT);
  assign clk_en   = tick;
  assign step_ack = tick && (state == ST_STEP);
  assign resetn   = (state != ST_HOLD);
  assign running  = (state == ST_RUN);

  tick_gen #(
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_tick_gen (
    .CLK    (CLK),
    .RESET  (RESET),
    .enable (enable),
    .reload (reload),
    .div    (div_q),
    .tick   (tick)
  );

  // Next-state logic. Soft reset beats everything; a run write beats a step
  // request. HALT keeps the counter parked at div so a step or resume always
  // starts a full period.
  always_comb begin
    state_next = state;
    reload     = 1'b0;
    if (srst) begin
      state_next = ST_HOLD;
      reload     = 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          if (tick && hold_last) begin
            state_next = run_next ? ST_RUN : ST_HALT;
          end
        end
        ST_RUN: begin
          if (!run_next) begin
            state_next = ST_HALT;
            reload     = 1'b1;
          end
        end
        ST_HALT: begin
          reload = 1'b1;
          if (run_next) begin
            state_next = ST_RUN;
          end else if (step_req && armed) begin
            state_next = ST_STEP;
          end
        end
        ST_STEP: begin
          if (tick) begin
            state_next = ST_HALT;
          end
        end
        default: state_next = ST_HOLD;
      endcase
    end
  end

  // Read mux samples current register values, so a read in a write cycle
  // returns the pre-write contents.
  always_comb begin
    rd_next = '0;
    case (cfg_addr)
      ADDR_CTRL:   rd_next = {31'b0, run_q};
      ADDR_DIV:    rd_next = 32'(div_q);
      ADDR_TICKS:  rd_next = ticks;
      ADDR_STATUS: rd_next = {29'b0, resetn, state};
      default:     rd_next = '0;
    endcase
  end

  // State, registers and hold counter. run/div/ticks survive a soft reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_HOLD;
      div_q     <= DIV_W'(DIV_DEFAULT - 1);
      run_q     <= 1'b1;
      ticks     <= '0;
      hold_cnt  <= '0;
      armed     <= 1'b1;
      supp      <= 1'b0;
      cfg_rdata <= '0;
    end else begin
      state     <= state_next;
      run_q     <= run_next;
      ticks     <= ticks + {31'b0, tick};
      supp      <= srst && (div_q == '0);
      cfg_rdata <= rd_next;
      if (div_wr) begin
        div_q <= cfg_wdata[DIV_W-1:0];
      end
      if (srst) begin
        hold_cnt <= '0;
      end else if ((state == ST_HOLD) && tick) begin
        hold_cnt <= hold_last ? '0 : hold_cnt + HOLD_W'(1);
      end
      // A step consumes the arm; any low sample of step_req re-arms.
      if (!step_req) begin
        armed <= 1'b1;
      end else if (step_ack) begin
        armed <= 1'b0;
      end
    end
  end

endmodule
